// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep tester.
// Holds the FSM encoding, counter widths and the golden table of F = !C && (!A || B).
package tt_sweep_pkg;

    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam logic [7:0] DEFAULT_EXPECTED = 8'h45;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

endpackage

// File: rtl/popcount_8.sv
// Combinational population count of an 8-bit vector (result 0..8).
module popcount_8 (
    input  logic [7:0] din,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, din[i]};
        end
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Drives all eight {A,B,C} patterns into a 3-input gate, captures F per pattern
// and compares the captured table against EXPECTED.
module truth_table_sweep
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE   = 1,  // hold cycles per pattern, 1..15
    parameter logic [7:0]  EXPECTED = DEFAULT_EXPECTED
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       F,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] TABLE,
    output logic       PASS,
    output logic [3:0] MISMATCH
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [3:0]       mismatch_now;
    logic             settle_done;
    logic             last_idx;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_idx    = &idx;

    popcount_8 u_popcount (
        .din   (TABLE ^ EXPECTED),
        .count (mismatch_now)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment ahead of the case keeps every path assigned,
    // so no latch is inferred for state_next.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (START) state_next = ST_DRIVE;
            ST_DRIVE:  if (settle_done) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = last_idx ? ST_FIN : ST_DRIVE;
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: TABLE is a plain 8-bit register, not a memory, so it is cleared by
    // reset along with everything else and an aborted sweep leaves nothing behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx        <= '0;
            settle_cnt <= '0;
            {A, B, C}  <= 3'b000;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            TABLE      <= '0;
            PASS       <= 1'b0;
            MISMATCH   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        TABLE      <= '0;
                        PASS       <= 1'b0;
                        MISMATCH   <= '0;
                        idx        <= '0;
                        settle_cnt <= '0;
                        {A, B, C}  <= 3'b000;
                        BUSY       <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    TABLE[idx] <= F;
                    // idx parks at 7; only a new START returns it to 0
                    if (last_idx) begin
                        {A, B, C} <= 3'b000;
                    end else begin
                        idx       <= idx + 1'b1;
                        {A, B, C} <= idx + 1'b1;
                    end
                end
                ST_FIN: begin
                    DONE     <= 1'b1;
                    BUSY     <= 1'b0;
                    PASS     <= (TABLE == EXPECTED);
                    MISMATCH <= mismatch_now;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=3), each wired to a
// lookup-table gate, checked against a reference built from the gate equation.
module tb_truth_table_sweep;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic       f_s     [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       c_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [7:0] table_s [2];
    logic [3:0] mism_s  [2];
    logic [7:0] f_tab   [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign f_s[0] = f_tab[0][{a_s[0], b_s[0], c_s[0]}];
    assign f_s[1] = f_tab[1][{a_s[1], b_s[1], c_s[1]}];

    truth_table_sweep #(.SETTLE(1)) dut0 (
        .CLK(clk), .RST(rst), .START(start_s[0]), .F(f_s[0]),
        .A(a_s[0]), .B(b_s[0]), .C(c_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]),
        .TABLE(table_s[0]), .PASS(pass_s[0]), .MISMATCH(mism_s[0])
    );

    truth_table_sweep #(.SETTLE(3)) dut1 (
        .CLK(clk), .RST(rst), .START(start_s[1]), .F(f_s[1]),
        .A(a_s[1]), .B(b_s[1]), .C(c_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]),
        .TABLE(table_s[1]), .PASS(pass_s[1]), .MISMATCH(mism_s[1])
    );

    function automatic int settle_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic gate(input logic a, input logic b, input logic c);
        return !c && (!a || b);
    endfunction

    // Golden table derived from the gate equation, bit index {A,B,C}
    function automatic logic [7:0] gate_table();
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            t[i] = gate(i[2], i[1], i[0]);
        end
        return t;
    endfunction

    // One complete sweep on unit u with the gate behaving as ftab; optionally
    // re-pulses START mid-sweep. Returns at the negedge where DONE is high.
    task automatic run_sweep(input int u, input logic [7:0] ftab, input bit poke);
        int         per;
        int         done_at;
        int         done_cnt;
        int         first_done;
        int         abc_err;
        int         busy_err;
        int         exp_mism;
        logic [7:0] gold;
        per        = settle_of(u) + 1;
        done_at    = 8 * per + 1;
        done_cnt   = 0;
        first_done = -1;
        abc_err    = 0;
        busy_err   = 0;
        exp_mism   = 0;
        gold       = gate_table();
        for (int i = 0; i < 8; i++) begin
            if (ftab[i] != gold[i]) exp_mism++;
        end
        f_tab[u]   = ftab;
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;

        tests++;
        if (busy_s[u] !== 1'b1 || table_s[u] !== 8'h00 || pass_s[u] !== 1'b0 || mism_s[u] !== 4'd0) begin
            fails++;
            $display("FAIL accept_clear u%0d: busy=%b table=%h pass=%b mism=%0d, want busy=1 table=00 pass=0 mism=0",
                     u, busy_s[u], table_s[u], pass_s[u], mism_s[u]);
        end

        for (int t = 0; t <= done_at; t++) begin
            if (t > 0) @(negedge clk);
            if (poke) start_s[u] = (t == 2 || t == 10);
            if (t < 8 * per) begin
                if ({a_s[u], b_s[u], c_s[u]} !== 3'(t / per)) abc_err++;
            end else if ({a_s[u], b_s[u], c_s[u]} !== 3'b000) begin
                abc_err++;
            end
            if (busy_s[u] !== ((t < done_at) ? 1'b1 : 1'b0)) busy_err++;
            if (done_s[u] === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = t;
            end
        end
        start_s[u] = 1'b0;

        tests++;
        if (abc_err != 0) begin
            fails++;
            $display("FAIL abc_sequence u%0d: %0d bad cycles, want 0", u, abc_err);
        end
        tests++;
        if (busy_err != 0) begin
            fails++;
            $display("FAIL busy_window u%0d: %0d bad cycles, want 0", u, busy_err);
        end
        tests++;
        if (first_done != done_at || done_cnt != 1) begin
            fails++;
            $display("FAIL done_timing u%0d: first at %0d count %0d, want at %0d count 1",
                     u, first_done, done_cnt, done_at);
        end
        tests++;
        if (table_s[u] !== ftab) begin
            fails++;
            $display("FAIL table u%0d: got %h want %h", u, table_s[u], ftab);
        end
        tests++;
        if (pass_s[u] !== (ftab == gold) || mism_s[u] !== 4'(exp_mism)) begin
            fails++;
            $display("FAIL verdict u%0d: pass=%b mism=%0d, want pass=%b mism=%0d",
                     u, pass_s[u], mism_s[u], (ftab == gold), exp_mism);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            tests++;
            if ({a_s[u], b_s[u], c_s[u], busy_s[u], done_s[u], pass_s[u]} !== 6'b0 ||
                table_s[u] !== 8'h00 || mism_s[u] !== 4'd0) begin
                fails++;
                $display("FAIL reset_state u%0d: abc=%b%b%b busy=%b done=%b table=%h pass=%b mism=%0d, want all 0",
                         u, a_s[u], b_s[u], c_s[u], busy_s[u], done_s[u], table_s[u], pass_s[u], mism_s[u]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden_gate();
        @(negedge clk);
        run_sweep(0, gate_table(), 1'b0);
    endtask

    task automatic test_tied_high();
        @(negedge clk);
        run_sweep(0, 8'hFF, 1'b0);
    endtask

    task automatic test_settle3();
        @(negedge clk);
        run_sweep(1, gate_table(), 1'b0);
    endtask

    task automatic test_random_tables();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            run_sweep(k % 2, 8'($urandom), 1'b0);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_tab;
        int         bad;
        exp_tab = 8'($urandom);
        bad     = 0;
        @(negedge clk);
        run_sweep(0, exp_tab, 1'b0);
        f_tab[0] = ~exp_tab;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (table_s[0] !== exp_tab || busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 ||
                {a_s[0], b_s[0], c_s[0]} !== 3'b000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_after_fin: %0d unstable cycles, want 0", bad);
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        bad = 0;
        @(negedge clk);
        run_sweep(0, gate_table(), 1'b1);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL start_not_queued: %0d busy/done cycles after sweep, want 0", bad);
        end
    endtask

    task automatic test_mid_sweep_reset();
        int bad;
        bad = 0;
        @(negedge clk);
        f_tab[0]   = gate_table();
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({a_s[0], b_s[0], c_s[0], busy_s[0], done_s[0], pass_s[0]} !== 6'b0 ||
            table_s[0] !== 8'h00 || mism_s[0] !== 4'd0) begin
            fails++;
            $display("FAIL abort_reset: abc=%b%b%b busy=%b done=%b table=%h pass=%b mism=%0d, want all 0",
                     a_s[0], b_s[0], c_s[0], busy_s[0], done_s[0], table_s[0], pass_s[0], mism_s[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || table_s[0] !== 8'h00) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_after_reset: %0d active cycles without START, want 0", bad);
        end
        run_sweep(0, gate_table(), 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_sweep(0, 8'hFF, 1'b0);
        run_sweep(0, gate_table(), 1'b0);
        run_sweep(0, gate_table(), 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        f_tab[0]   = 8'h00;
        f_tab[1]   = 8'h00;
        test_reset();
        test_golden_gate();
        test_tied_high();
        test_settle3();
        test_random_tables();
        test_hold();
        test_start_ignored();
        test_mid_sweep_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of cycles {A,B,C} is held before F is sampled (legal range 1..15).
REQ-002 SHALL have parameter EXPECTED, default 8'h45, meaning the golden truth table of F = !C && (!A || B), bit index {A,B,C}.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port START, input, 1 bit, sweep request sampled in IDLE.
REQ-006 SHALL have port F, input, 1 bit, the response of the downstream gate under test.
REQ-007 SHALL have ports A, B, C, outputs, 1 bit each, registered stimulus to the gate under test.
REQ-008 SHALL have port BUSY, output, 1 bit, high from the cycle after START acceptance until DONE.
REQ-009 SHALL have port DONE, output, 1 bit, a single-cycle pulse at sweep completion.
REQ-010 SHALL have port TABLE, output, 8 bits, captured F per index {A,B,C}.
REQ-011 SHALL have port PASS, output, 1 bit, high when TABLE == EXPECTED after a completed sweep.
REQ-012 SHALL have port MISMATCH, output, 4 bits, the popcount of TABLE ^ EXPECTED (0..8).

Function
REQ-013 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and FIN.
REQ-014 In IDLE with START=1, SHALL clear TABLE, PASS and MISMATCH, set idx=0 and enter DRIVE.
REQ-015 In DRIVE, SHALL drive {A,B,C}=idx and remain for exactly SETTLE cycles (settle counter 0..SETTLE-1), then enter SAMPLE.
REQ-016 In SAMPLE, SHALL write TABLE[idx]<=F with {A,B,C} unchanged; if idx==7, enter FIN, otherwise increment idx and return to DRIVE.
REQ-017 In FIN, SHALL assert DONE for one cycle, register PASS and MISMATCH from the final TABLE, deassert BUSY and return to IDLE.
REQ-018 SHALL take SETTLE+1 cycles per pattern; DONE SHALL go high 8*(SETTLE+1)+1 cycles after the START-accept edge (17 cycles for SETTLE=1).
REQ-019 SHALL hold TABLE, PASS and MISMATCH stable from FIN until the next accepted START or reset.
REQ-020 SHALL ignore START while BUSY=1, and SHALL not queue it.
REQ-021 SHALL accept START in the cycle immediately after DONE (back-to-back sweeps).
REQ-022 idx is 3 bits; SHALL not wrap past 7 within a sweep; the 7->0 transition SHALL occur only via a new START.
REQ-023 SHALL hold A, B and C at 0 in IDLE and FIN.

Reset
REQ-024 On RST=1, SHALL immediately set state=IDLE, idx=0, settle counter=0, A=B=C=0, BUSY=0, DONE=0, TABLE=0, PASS=0 and MISMATCH=0.
REQ-025 On reset mid-sweep, SHALL abort the sweep with no DONE pulse and leave no partial TABLE visible.
REQ-026 SHALL require START to be reasserted to begin a sweep after RST deasserts.

Structure
REQ-027 Package tt_sweep_pkg SHALL hold the state encoding, the idx width (3) and the default EXPECTED constant 8'h45.
REQ-028 Mismatch counting SHALL be done in one sub-module, popcount_8 (8-bit in, 4-bit out, combinational).
REQ-029 SETTLE and EXPECTED SHALL be overridable per instance without RTL edits.

Verification
REQ-030 Connect F to a model of !C && (!A||B), SETTLE=1, pulse START -> DONE at cycle 17, TABLE=8'h45, PASS=1, MISMATCH=0.
REQ-031 Connect F tied to 1 -> TABLE=8'hFF, PASS=0, MISMATCH=5.
REQ-032 With SETTLE=3, pulse START -> A/B/C each held 3 cycles before every sample, and DONE at cycle 33.
REQ-033 Assert START again at cycles 2 and 10 of a sweep -> no effect, exactly one DONE.
REQ-034 Assert RST at cycle 9 of a sweep -> all outputs 0 at once, no DONE; a following START gives a full, correct sweep.
REQ-035 Assert START in the cycle after DONE -> a second sweep starts, TABLE is cleared, and the results repeat.
